hl_inject_enc: RTL and testbench
================================

Name: hl_inject_enc

Overview:
- Source-side header encoder and packetizer for the hierarchical-leader (HL) multicast NoC.
- Accepts a unicast or multicast send request and a body-data stream from the local core.
- Builds the HL header fields that per-router decoders consume: um_type, uni_dst, mult_dst, src_pos, src_dst.
- Emits head/body/tail flits into the router's local input port under credit-based flow control.

Parameters:
- MY_XPOS, 0, node X coordinate.
- MY_YPOS, 0, node Y coordinate.
- XSIZE, 8, mesh columns. Mesh rows are `ROW.
- DATAW, 64, flit payload width. Must be at least 1+(`NODEW+1)+(`MADDR+1)+2+(`MSRC_BW+1)+LENW.
- LENW, 4, width of the body-flit count field.
- BUF_DEPTH, 4, downstream input-buffer depth, equal to the initial credit count.

Ports:
- clk  in  1  clock.
- rst_  in  1  asynchronous active-low reset.
- req_valid  in  1  send request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_mult  in  1  0 = unicast, 1 = multicast.
- req_uni_dst  in  `NODEW+1  unicast destination node id.
- req_mult_dst  in  `MADDR+1  multicast destination bitmap, bit n = node n.
- req_len  in  LENW  number of body flits, 0..2^LENW-1.
- data_valid  in  1  body word valid.
- data_ready  out  1  body word consumed when data_valid && data_ready.
- data_in  in  DATAW  body payload.
- flit_out  out  DATAW+2  {type[1:0], payload}. Type: 00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL.
- flit_valid  out  1  flit_out valid, asserted for one cycle per flit.
- credit_in  in  1  one buffer slot freed downstream.
- busy  out  1  state != IDLE.
- drop  out  1  one-cycle pulse when a request is discarded.

Behaviour:
- Reset (async, rst_ = 0):
  - state = IDLE; credits = BUF_DEPTH.
  - flit_valid, flit_out, drop = 0; latched fields = 0.
  - A reset mid-packet abandons the packet; no TAIL is emitted.
- Header construction:
  - MY_POS = MY_XPOS*`ROW + MY_YPOS.
  - Header payload is packed from the LSB upward: um_type, uni_dst, mult_dst, src_pos, src_dst, len. Remaining bits are 0.
  - Unicast: mult_dst = 0 and src_pos = 0.
  - Multicast: uni_dst = 0 and src_pos = {MY_XPOS >= XSIZE/2, MY_YPOS >= `ROW/2}.
  - src_dst = MY_POS[`MSRC_BW:0].
- FSM with states IDLE, HEAD, BODY:
  - IDLE:
    - req_ready = 1.
    - On accept, latch all request fields and go to HEAD.
    - Exception: if req_mult = 1 and req_mult_dst = 0, pulse drop in the next cycle and stay in IDLE.
  - HEAD:
    - If credits > 0, issue the header and decrement credits.
    - Header type is HEADTAIL when len = 0 (go to IDLE), otherwise HEAD (go to BODY; body counter = len).
    - If credits = 0, stall in HEAD.
  - BODY:
    - data_ready = (credits > 0), combinational.
    - Each handshake issues one flit with payload = data_in and decrements credits and the counter.
    - The flit on which the counter reaches 0 is typed TAIL; go to IDLE.
    - Non-last flits are typed BODY.
- Output timing:
  - flit_out and flit_valid are registered: a flit issued in cycle N has flit_valid = 1 in cycle N+1.
  - Request accepted in cycle T: header flit_valid at T+2 at the earliest.
  - First body flit at T+3 at the earliest. Throughput is 1 flit/cycle with no bubbles.
- Credits:
  - Width clog2(BUF_DEPTH+1).
  - Issue and credit_in in the same cycle: credits unchanged.
  - credit_in while credits = BUF_DEPTH is ignored (saturate, no wrap).
  - Issue never happens when credits = 0.
- req_ready is 0 outside IDLE. The next request may be accepted in the cycle after the TAIL/HEADTAIL issue.
- busy is 1 in HEAD and BODY.

Optional Feature:
- Macro: HL_ENC_SELF_FILTER_EN.
- When defined:
  - Multicast bit MY_POS is cleared from mult_dst before the header is built.
  - A resulting empty bitmap drops the request (drop pulse).
  - A resulting single-bit bitmap is converted to unicast: um_type = 0, uni_dst = index of the set bit, mult_dst = 0, src_pos = 0.
- When undefined: mult_dst is forwarded unmodified, including the self bit.

Test Plan:
- Unicast, req_uni_dst = 5, len = 2, credits full, data always valid: HEAD at T+2 with um_type = 0 and uni_dst = 5; BODY at T+3; TAIL at T+4; credits = 1 afterward with no credit_in.
- Multicast, mult_dst = 0x0000_0F00, len = 0, at MY_XPOS = 5, MY_YPOS = 1: a single HEADTAIL flit with um_type = 1, src_pos = 2'b10, src_dst = 21.
- BUF_DEPTH = 4, len = 6, no credit_in until cycle T+8: exactly 4 flits, then stall with data_ready = 0; each credit_in pulse releases exactly one flit; TAIL is last.
- Simultaneous credit_in and issue every cycle from full: credits stay at 4; spurious credit_in at full keeps 4.
- req_mult = 1, mult_dst = 0: request accepted, drop = 1 for one cycle, no flit_valid, busy stays 0.
- rst_ asserted during BODY after 1 of 3 body flits: outputs clear immediately; after release, credits = 4, state IDLE, and the next request emits a normal HEAD.

Source files
------------

// File: rtl/hl_inject_enc.sv
// HL multicast NoC source encoder: latches a send request, builds the HL header and
// streams HEAD/BODY/TAIL flits under credit flow control. Optional: HL_ENC_SELF_FILTER_EN.
`ifndef ROW
`define ROW 4
`endif
`ifndef NODEW
`define NODEW 4
`endif
`ifndef MADDR
`define MADDR 31
`endif
`ifndef MSRC_BW
`define MSRC_BW 4
`endif

module hl_inject_enc #(
    parameter int MY_XPOS   = 0,
    parameter int MY_YPOS   = 0,
    parameter int XSIZE     = 8,
    parameter int DATAW     = 64,
    parameter int LENW      = 4,
    parameter int BUF_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_mult,
    input  logic [`NODEW:0]    req_uni_dst,
    input  logic [`MADDR:0]    req_mult_dst,
    input  logic [LENW-1:0]    req_len,
    input  logic               data_valid,
    output logic               data_ready,
    input  logic [DATAW-1:0]   data_in,
    output logic [DATAW+1:0]   flit_out,
    output logic               flit_valid,
    input  logic               credit_in,
    output logic               busy,
    output logic               drop,
    output logic [1:0]         state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // req_ready and data_ready depend only on registered state, never on the valids.

    localparam int UNIW     = `NODEW + 1;
    localparam int MULTW    = `MADDR + 1;
    localparam int SDW      = `MSRC_BW + 1;
    localparam int UNI_LSB  = 1;
    localparam int MULT_LSB = UNI_LSB + UNIW;
    localparam int SP_LSB   = MULT_LSB + MULTW;
    localparam int SD_LSB   = SP_LSB + 2;
    localparam int LEN_LSB  = SD_LSB + SDW;
    localparam int CW       = $clog2(BUF_DEPTH + 1);
    localparam int MY_POS   = MY_XPOS * `ROW + MY_YPOS;

    localparam logic [1:0]     SRC_POS = {(MY_XPOS >= XSIZE / 2), (MY_YPOS >= `ROW / 2)};
    localparam logic [SDW-1:0] SRC_DST = SDW'(MY_POS);

    localparam logic [1:0] T_HEAD     = 2'b00;
    localparam logic [1:0] T_BODY     = 2'b01;
    localparam logic [1:0] T_TAIL     = 2'b10;
    localparam logic [1:0] T_HEADTAIL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     credits;
    logic [LENW-1:0]   cnt, cnt_nxt;
    logic              lat_mult;
    logic [UNIW-1:0]   lat_uni;
    logic [MULTW-1:0]  lat_mdst;
    logic [LENW-1:0]   lat_len;

    logic              acc_mult;
    logic [UNIW-1:0]   acc_uni;
    logic [MULTW-1:0]  acc_mdst;
    logic              acc_drop;
    logic              load;
    logic              drop_nxt;
    logic              issue;
    logic [DATAW+1:0]  issue_flit;
    logic [DATAW-1:0]  hdr;
    logic              has_credit;

    assign has_credit = (credits != '0);
    assign busy       = (state != S_IDLE);
    assign state_dbg  = state;

`ifdef HL_ENC_SELF_FILTER_EN
    localparam logic [MULTW-1:0] SELF_MASK = (MY_POS < MULTW) ? (MULTW'(1) << MY_POS) : '0;

    logic [MULTW-1:0] filt;
    logic             one_hot;
    logic [UNIW-1:0]  hot_idx;

    // Self bit is removed first; a lone remaining target travels cheaper as unicast.
    always_comb begin
        filt    = req_mult_dst & ~SELF_MASK;
        one_hot = (filt != '0) && ((filt & (filt - MULTW'(1))) == '0);
        hot_idx = '0;
        for (int i = 0; i < MULTW; i++) begin
            if (filt[i]) hot_idx = UNIW'(i);
        end
    end

    always_comb begin
        acc_mult = req_mult;
        acc_uni  = req_uni_dst;
        acc_mdst = '0;
        acc_drop = 1'b0;
        if (req_mult) begin
            if (filt == '0) begin
                acc_drop = 1'b1;
            end else if (one_hot) begin
                acc_mult = 1'b0;
                acc_uni  = hot_idx;
            end else begin
                acc_uni  = '0;
                acc_mdst = filt;
            end
        end
    end
`else
    always_comb begin
        acc_mult = req_mult;
        acc_uni  = req_uni_dst;
        acc_mdst = '0;
        acc_drop = 1'b0;
        if (req_mult) begin
            acc_uni  = '0;
            acc_mdst = req_mult_dst;
            acc_drop = (req_mult_dst == '0);
        end
    end
`endif

    always_comb begin
        hdr                       = '0;
        hdr[0]                    = lat_mult;
        hdr[UNI_LSB +: UNIW]      = lat_uni;
        hdr[MULT_LSB +: MULTW]    = lat_mdst;
        hdr[SP_LSB +: 2]          = lat_mult ? SRC_POS : 2'b00;
        hdr[SD_LSB +: SDW]        = SRC_DST;
        hdr[LEN_LSB +: LENW]      = lat_len;
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_ready  = 1'b0;
        data_ready = 1'b0;
        load       = 1'b0;
        drop_nxt   = 1'b0;
        issue      = 1'b0;
        issue_flit = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (acc_drop) begin
                        drop_nxt = 1'b1;
                    end else begin
                        load      = 1'b1;
                        state_nxt = S_HEAD;
                    end
                end
            end
            S_HEAD: begin
                if (has_credit) begin
                    issue = 1'b1;
                    if (lat_len == '0) begin
                        issue_flit = {T_HEADTAIL, hdr};
                        state_nxt  = S_IDLE;
                    end else begin
                        issue_flit = {T_HEAD, hdr};
                        cnt_nxt    = lat_len;
                        state_nxt  = S_BODY;
                    end
                end
            end
            S_BODY: begin
                data_ready = has_credit;
                if (data_valid && has_credit) begin
                    issue   = 1'b1;
                    cnt_nxt = cnt - LENW'(1);
                    if (cnt == LENW'(1)) begin
                        issue_flit = {T_TAIL, data_in};
                        state_nxt  = S_IDLE;
                    end else begin
                        issue_flit = {T_BODY, data_in};
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lat_mult   <= 1'b0;
            lat_uni    <= '0;
            lat_mdst   <= '0;
            lat_len    <= '0;
            flit_out   <= '0;
            flit_valid <= 1'b0;
            drop       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            flit_valid <= issue;
            drop       <= drop_nxt;
            if (issue) flit_out <= issue_flit;
            if (load) begin
                lat_mult <= acc_mult;
                lat_uni  <= acc_uni;
                lat_mdst <= acc_mdst;
                lat_len  <= req_len;
            end
        end
    end

    // A returned slot and a send in the same cycle cancel; returns at full are ignored.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            credits <= CW'(BUF_DEPTH);
        end else if (issue && !credit_in) begin
            credits <= credits - CW'(1);
        end else if (!issue && credit_in && credits != CW'(BUF_DEPTH)) begin
            credits <= credits + CW'(1);
        end
    end

endmodule

// File: tb/tb_hl_inject_enc.sv
// Bench for hl_inject_enc at node (5,1): directed scenarios plus random packets checked
// against a flit-list model built from the header rules.
`ifndef ROW
`define ROW 4
`endif
`ifndef NODEW
`define NODEW 4
`endif
`ifndef MADDR
`define MADDR 31
`endif
`ifndef MSRC_BW
`define MSRC_BW 4
`endif

module tb_hl_inject_enc;
    localparam int MY_X = 5;
    localparam int MY_Y = 1;
    localparam int XS   = 8;
    localparam int DW   = 64;
    localparam int LW   = 4;
    localparam int BD   = 4;
    localparam int FW   = DW + 2;
    localparam int MY_POS_TB = MY_X * `ROW + MY_Y;
    localparam int UNI_OFF  = 1;
    localparam int MULT_OFF = UNI_OFF + `NODEW + 1;
    localparam int SP_OFF   = MULT_OFF + `MADDR + 1;
    localparam int SD_OFF   = SP_OFF + 2;
    localparam int LEN_OFF  = SD_OFF + `MSRC_BW + 1;

    logic              clk;
    logic              rst_;
    logic              req_valid;
    logic              req_ready;
    logic              req_mult;
    logic [`NODEW:0]   req_uni_dst;
    logic [`MADDR:0]   req_mult_dst;
    logic [LW-1:0]     req_len;
    logic              data_valid;
    logic              data_ready;
    logic [DW-1:0]     data_in;
    logic [FW-1:0]     flit_out;
    logic              flit_valid;
    logic              credit_in;
    logic              busy;
    logic              drop;
    logic [1:0]        state_dbg;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic [FW-1:0] exp_q[$];
    logic [DW-1:0] data_words[$];
    int            rx_cyc_q[$];
    logic [FW-1:0] last_flit = '0;
    int rx_count = 0;
    int drop_cnt = 0;
    int exp_drops = 0;
    int outstanding = 0;
    int credit_mode = 0;   // 0 manual only, 1 random return, 2 constant credit_in
    int man_req = 0;
    int man_done = 0;
    bit dv_always = 1'b1;

    hl_inject_enc #(
        .MY_XPOS(MY_X), .MY_YPOS(MY_Y), .XSIZE(XS), .DATAW(DW), .LENW(LW), .BUF_DEPTH(BD)
    ) dut (
        .clk(clk), .rst_(rst_),
        .req_valid(req_valid), .req_ready(req_ready), .req_mult(req_mult),
        .req_uni_dst(req_uni_dst), .req_mult_dst(req_mult_dst), .req_len(req_len),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .flit_out(flit_out), .flit_valid(flit_valid), .credit_in(credit_in),
        .busy(busy), .drop(drop), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Reference model: expected flit list for one request.
    task automatic model_req(input bit mult, input int uni, input logic [31:0] mdst, input int len);
        bit m;
        int u;
        int sp;
        int ones;
        logic [31:0] md;
        logic [DW-1:0] hdr;
        logic [DW-1:0] w;
        m  = mult;
        u  = uni;
        md = mdst;
        if (!mult) begin
            md = '0;
        end else begin
`ifdef HL_ENC_SELF_FILTER_EN
            md[MY_POS_TB] = 1'b0;
`endif
            ones = $countones(md);
            if (ones == 0) begin
                exp_drops++;
                return;
            end
`ifdef HL_ENC_SELF_FILTER_EN
            if (ones == 1) begin
                m = 1'b0;
                for (int i = 0; i < 32; i++) if (md[i]) u = i;
                md = '0;
            end
`endif
            if (m) u = 0;
        end
        sp = m ? (((MY_X >= XS / 2) ? 2 : 0) + ((MY_Y >= `ROW / 2) ? 1 : 0)) : 0;
        hdr = DW'(m) | (DW'(u) << UNI_OFF) | (DW'(md) << MULT_OFF) | (DW'(sp) << SP_OFF)
            | (DW'(MY_POS_TB % (1 << (`MSRC_BW + 1))) << SD_OFF) | (DW'(len) << LEN_OFF);
        exp_q.push_back({(len == 0) ? 2'b11 : 2'b00, hdr});
        for (int i = 0; i < len; i++) begin
            w = {$urandom, $urandom};
            data_words.push_back(w);
            exp_q.push_back({(i == len - 1) ? 2'b10 : 2'b01, w});
        end
    endtask

    // driver: request channel
    task automatic send_req(input bit mult, input int uni, input logic [31:0] mdst,
                            input int len, output int t);
        model_req(mult, uni, mdst, len);
        req_mult     = mult;
        req_uni_dst  = uni[`NODEW:0];
        req_mult_dst = mdst;
        req_len      = LW'(len);
        req_valid    = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (req_ready) break;
            tick(1);
        end
        check_eq("req_ready", req_ready, 1'b1);
        t = cyc;
        tick(1);
        req_valid = 1'b0;
    endtask

    // driver: body data
    initial begin
        data_valid = 1'b0;
        data_in    = '0;
        forever begin
            @(negedge clk);
            if (data_words.size() > 0) begin
                data_valid = dv_always || ($urandom_range(0, 3) != 0);
                data_in    = data_words[0];
                if (data_valid && data_ready) void'(data_words.pop_front());
            end else begin
                data_valid = ($urandom_range(0, 1) == 1);
                data_in    = {$urandom, $urandom};
            end
        end
    end

    // driver: downstream credit return
    initial begin
        credit_in = 1'b0;
        forever begin
            @(negedge clk);
            if (credit_mode == 2) begin
                credit_in = 1'b1;
            end else if (man_done < man_req) begin
                credit_in = 1'b1;
                man_done++;
                outstanding--;
            end else if (credit_mode == 1 && outstanding > 0 && $urandom_range(0, 2) != 0) begin
                credit_in = 1'b1;
                outstanding--;
            end else begin
                credit_in = 1'b0;
            end
        end
    end

    // scoreboard / monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst_) begin
                if (drop) drop_cnt++;
                if (flit_valid) begin
                    rx_count++;
                    rx_cyc_q.push_back(cyc);
                    last_flit = flit_out;
                    if (credit_mode != 2) outstanding++;
                    check_eq("flit_expected", (exp_q.size() > 0), 1'b1);
                    if (exp_q.size() > 0) check_eq("flit", flit_out, exp_q.pop_front());
                    check_eq("credit_overrun", (outstanding <= BD), 1'b1);
                end
            end
        end
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int t;
        int b;
        int dc;
        int mult;
        int sel;
        logic [31:0] md;
        rst_ = 1'b0;
        req_valid = 1'b0;
        req_mult = 1'b0;
        req_uni_dst = '0;
        req_mult_dst = '0;
        req_len = '0;
        tick(3);
        check_eq("rst_flit_valid", flit_valid, 1'b0);
        check_eq("rst_flit_out", flit_out, '0);
        check_eq("rst_drop", drop, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_state", state_dbg, 2'd0);
        check_eq("rst_credits", dut.credits, BD);
        rst_ = 1'b1;
        tick(2);
        check_eq("idle_req_ready", req_ready, 1'b1);

        // unicast, len 2, latency
        rx_cyc_q.delete();
        send_req(1'b0, 5, 32'h0, 2, t);
        tick(6);
        check_eq("uni_nflits", rx_cyc_q.size(), 3);
        if (rx_cyc_q.size() == 3) begin
            check_eq("uni_head_cyc", rx_cyc_q[0], t + 2);
            check_eq("uni_body_cyc", rx_cyc_q[1], t + 3);
            check_eq("uni_tail_cyc", rx_cyc_q[2], t + 4);
        end
        check_eq("uni_credits_left", dut.credits, 1);
        check_eq("uni_busy_done", busy, 1'b0);
        man_req += 3;
        tick(4);
        check_eq("uni_credits_back", dut.credits, BD);

        // multicast headtail
        rx_cyc_q.delete();
        send_req(1'b1, 7, 32'h0000_0F00, 0, t);
        tick(4);
        check_eq("mc_nflits", rx_cyc_q.size(), 1);
        if (rx_cyc_q.size() == 1) check_eq("mc_cyc", rx_cyc_q[0], t + 2);
        check_eq("mc_type", last_flit[FW-1 -: 2], 2'b11);
        check_eq("mc_um_type", last_flit[0], 1'b1);
        check_eq("mc_uni_zero", last_flit[UNI_OFF +: 5], 5'd0);
        check_eq("mc_mult_dst", last_flit[MULT_OFF +: 32], 32'h0000_0F00);
        check_eq("mc_src_pos", last_flit[SP_OFF +: 2], 2'b10);
        check_eq("mc_src_dst", last_flit[SD_OFF +: 5], 5'd21);
        man_req += 1;
        tick(3);

        // credit starvation with len 6
        b = rx_count;
        send_req(1'b0, $urandom_range(0, 31), 32'h0, 6, t);
        while (cyc < t + 7) tick(1);
        check_eq("stall_nflits", rx_count - b, 4);
        check_eq("stall_data_ready", data_ready, 1'b0);
        check_eq("stall_busy", busy, 1'b1);
        for (int k = 0; k < 3; k++) begin
            man_req++;
            tick(4);
            check_eq("stall_release", rx_count - b, 5 + k);
            check_eq("stall_ready_low", data_ready, 1'b0);
        end
        check_eq("stall_done_busy", busy, 1'b0);
        check_eq("stall_exp_empty", exp_q.size(), 0);
        man_req += 4;
        tick(6);
        check_eq("stall_credits_back", dut.credits, BD);

        // credit_in every cycle from full
        credit_mode = 2;
        tick(2);
        check_eq("echo_idle_credits", dut.credits, BD);
        rx_cyc_q.delete();
        send_req(1'b0, $urandom_range(0, 31), 32'h0, 5, t);
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check_eq("echo_credits", dut.credits, BD);
        end
        check_eq("echo_nflits", rx_cyc_q.size(), 6);
        for (int i = 0; i < rx_cyc_q.size(); i++) check_eq("echo_no_bubble", rx_cyc_q[i], t + 2 + i);
        credit_mode = 0;
        tick(2);
        check_eq("echo_after_credits", dut.credits, BD);

        // empty multicast bitmap is dropped
        b  = rx_count;
        dc = drop_cnt;
        send_req(1'b1, 3, 32'h0, 2, t);
        check_eq("drop_pulse", drop, 1'b1);
        check_eq("drop_busy", busy, 1'b0);
        tick(1);
        check_eq("drop_one_cycle", drop, 1'b0);
        check_eq("drop_busy2", busy, 1'b0);
        tick(3);
        check_eq("drop_no_flit", rx_count - b, 0);
        check_eq("drop_count", drop_cnt - dc, 1);

        // reset in the middle of a body
        b = rx_count;
        send_req(1'b0, 9, 32'h0, 3, t);
        for (int k = 0; k < 30; k++) begin
            if (rx_count - b >= 2) break;
            tick(1);
        end
        check_eq("mid_reset_progress", rx_count - b, 2);
        rst_ = 1'b0;
        #1;
        check_eq("mid_reset_valid", flit_valid, 1'b0);
        check_eq("mid_reset_flit", flit_out, '0);
        check_eq("mid_reset_busy", busy, 1'b0);
        check_eq("mid_reset_state", state_dbg, 2'd0);
        exp_q.delete();
        data_words.delete();
        outstanding = 0;
        tick(2);
        rst_ = 1'b1;
        tick(1);
        check_eq("post_reset_credits", dut.credits, BD);
        check_eq("post_reset_state", state_dbg, 2'd0);
        check_eq("post_reset_ready", req_ready, 1'b1);
        rx_cyc_q.delete();
        send_req(1'b0, 12, 32'h0, 1, t);
        tick(4);
        check_eq("post_reset_nflits", rx_cyc_q.size(), 2);
        if (rx_cyc_q.size() == 2) check_eq("post_reset_head_cyc", rx_cyc_q[0], t + 2);

        // random traffic
        credit_mode = 1;
        dv_always   = 1'b0;
        for (int p = 0; p < 40; p++) begin
            tick($urandom_range(0, 3));
            mult = $urandom_range(0, 1);
            sel  = $urandom_range(0, 4);
            case (sel)
                0: md = 32'h0;
                1: md = 32'h1 << $urandom_range(0, 31);
                2: md = (32'h1 << MY_POS_TB) | (32'h1 << $urandom_range(0, 31));
                3: md = 32'h1 << MY_POS_TB;
                default: md = $urandom;
            endcase
            send_req(mult[0], $urandom_range(0, 31), md, $urandom_range(0, 15), t);
        end
        for (int k = 0; k < 3000; k++) begin
            if (exp_q.size() == 0 && !busy && outstanding == 0 && !flit_valid) break;
            tick(1);
        end
        tick(3);
        check_eq("rand_exp_empty", exp_q.size(), 0);
        check_eq("rand_words_used", data_words.size(), 0);
        check_eq("rand_busy", busy, 1'b0);
        check_eq("rand_credits", dut.credits, BD);
        check_eq("rand_drops", drop_cnt, exp_drops);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
